iiitb_brg_prog: RTL and testbench

//  Programmable UART baud-rate generator: successor to the fixed 4-rate divider.

---
 rtl/iiitb_brg_pkg.sv | 21 ++
 rtl/iiitb_brg_modcnt.sv | 38 +++
 rtl/iiitb_brg_prog.sv | 157 +++++++++++++++
 tb/tb_iiitb_brg_prog.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/iiitb_brg_pkg.sv
// Shared definitions for the programmable UART baud-rate generator:
// preset-select encodings, default preset divisors, minimum legal divisor
// and default oversample ratio.
package iiitb_brg_pkg;

  typedef enum logic [1:0] {
    SEL_115200 = 2'b00,
    SEL_38400  = 2'b01,
    SEL_19200  = 2'b10,
    SEL_9600   = 2'b11
  } sel_e;

  localparam int unsigned DIV_W_DEF = 16;
  localparam int unsigned OSR_DEF   = 16;
  localparam int unsigned PRE0_DEF  = 68;   // 115200 bps @125 MHz, OSR 16
  localparam int unsigned PRE1_DEF  = 203;  // 38400
  localparam int unsigned PRE2_DEF  = 407;  // 19200
  localparam int unsigned PRE3_DEF  = 814;  // 9600
  localparam int unsigned MIN_DIV   = 2;

endpackage

// File: rtl/iiitb_brg_modcnt.sv
// Generic modulo-N counter with runtime terminal value.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   inc          : advance the count this cycle
//   clr          : force count to 0 (has priority over inc)
//   last         : terminal value N-1; count runs 0..last
//   cnt          : current count
//   wrap         : combinational, high when inc is set and cnt==last
module iiitb_brg_modcnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap  = inc && (cnt_q == last);
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (wrap) cnt_d = '0;
    else if (inc)  cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/iiitb_brg_prog.sv
// Programmable UART baud-rate generator.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   en           : run enable; low holds counters/outputs at 0
//   sel          : preset divisor select
//   use_custom   : take div_cfg instead of the preset
//   div_cfg      : custom divisor (clk cycles per oversample tick)
//   cfg_load     : 1-cycle pulse capturing {sel,use_custom,div_cfg}
//   sync_rst     : 1-cycle pulse restarting the baud phase
//   tick_os      : pulse every active divisor clocks
//   baud_tick    : pulse every OSR tick_os
//   clkout       : 50% duty square wave at the baud rate
//   cfg_pend     : captured divisor not yet applied
//   cfg_err      : sticky: last load requested divisor <2 (clamped to 2)
module iiitb_brg_prog
  import iiitb_brg_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter int unsigned OSR   = OSR_DEF,
  parameter int unsigned PRE0  = PRE0_DEF,
  parameter int unsigned PRE1  = PRE1_DEF,
  parameter int unsigned PRE2  = PRE2_DEF,
  parameter int unsigned PRE3  = PRE3_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       sel,
  input  logic             use_custom,
  input  logic [DIV_W-1:0] div_cfg,
  input  logic             cfg_load,
  input  logic             sync_rst,
  output logic             tick_os,
  output logic             baud_tick,
  output logic             clkout,
  output logic             cfg_pend,
  output logic             cfg_err
);

  localparam int unsigned     OS_W    = $clog2(OSR);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OSR / 2 - 1);

  logic             run_q, run_d;
  logic             tick_os_q, tick_os_d;
  logic             baud_tick_q, baud_tick_d;
  logic             clkout_q, clkout_d;
  logic             cfg_pend_q, cfg_pend_d;
  logic             cfg_err_q, cfg_err_d;
  logic [DIV_W-1:0] active_div_q, active_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;

  logic [DIV_W-1:0] pre_cnt, pre_last;
  logic [OS_W-1:0]  os_cnt;
  logic             pre_inc, pre_clr, pre_wrap, os_wrap;
  logic [DIV_W-1:0] preset, load_raw, load_val;
  logic             load_bad, apply_ok;
  sel_e             sel_v;

  // run_q delays counting by one cycle after en rises, so the first tick
  // lands active_div+1 clocks after enable.
  always_comb begin
    run_d    = en;
    pre_clr  = !en || sync_rst;
    pre_inc  = en && run_q && !sync_rst;
    pre_last = active_div_q - DIV_W'(1);
  end

  iiitb_brg_modcnt #(.W(DIV_W)) u_pre (
    .clk(clk), .reset_n(reset_n), .inc(pre_inc), .clr(pre_clr),
    .last(pre_last), .cnt(pre_cnt), .wrap(pre_wrap)
  );

  // The oversample stage advances on the same edge that raises tick_os, so
  // its wrap flags the OSR-th tick and registers straight into baud_tick.
  iiitb_brg_modcnt #(.W(OS_W)) u_os (
    .clk(clk), .reset_n(reset_n), .inc(pre_wrap), .clr(pre_clr),
    .last(OS_LAST), .cnt(os_cnt), .wrap(os_wrap)
  );

  always_comb begin
    tick_os_d   = pre_wrap;
    baud_tick_d = os_wrap;
    clkout_d    = clkout_q;
    if (pre_clr)
      clkout_d = 1'b0;
    else if (pre_wrap && (os_cnt == OS_HALF || os_cnt == OS_LAST))
      clkout_d = !clkout_q;
  end

  always_comb begin
    sel_v = sel_e'(sel);
    case (sel_v)
      SEL_115200: preset = DIV_W'(PRE0);
      SEL_38400:  preset = DIV_W'(PRE1);
      SEL_19200:  preset = DIV_W'(PRE2);
      default:    preset = DIV_W'(PRE3);
    endcase
  end

  // Divisor only changes at a prescaler wrap, when stopped, or on a phase
  // restart; in each case pre_cnt restarts at 0 so no period is mixed.
  always_comb begin
    load_raw     = use_custom ? div_cfg : preset;
    load_bad     = load_raw < DIV_W'(MIN_DIV);
    load_val     = load_bad ? DIV_W'(MIN_DIV) : load_raw;
    apply_ok     = pre_wrap || !en || sync_rst;
    active_div_d = active_div_q;
    pend_div_d   = pend_div_q;
    cfg_pend_d   = cfg_pend_q;
    cfg_err_d    = cfg_err_q;
    if (cfg_load) begin
      pend_div_d = load_val;
      cfg_err_d  = load_bad;
      if (sync_rst) begin
        active_div_d = load_val;
        cfg_pend_d   = 1'b0;
      end else begin
        // A simultaneous wrap still takes the previously pending value.
        if (cfg_pend_q && apply_ok) active_div_d = pend_div_q;
        cfg_pend_d = 1'b1;
      end
    end else if (cfg_pend_q && apply_ok) begin
      active_div_d = pend_div_q;
      cfg_pend_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q        <= 1'b0;
      tick_os_q    <= 1'b0;
      baud_tick_q  <= 1'b0;
      clkout_q     <= 1'b0;
      cfg_pend_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      active_div_q <= DIV_W'(PRE0);
      pend_div_q   <= DIV_W'(PRE0);
    end else begin
      run_q        <= run_d;
      tick_os_q    <= tick_os_d;
      baud_tick_q  <= baud_tick_d;
      clkout_q     <= clkout_d;
      cfg_pend_q   <= cfg_pend_d;
      cfg_err_q    <= cfg_err_d;
      active_div_q <= active_div_d;
      pend_div_q   <= pend_div_d;
    end
  end

  assign tick_os   = tick_os_q;
  assign baud_tick = baud_tick_q;
  assign clkout    = clkout_q;
  assign cfg_pend  = cfg_pend_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_iiitb_brg_prog.sv
// Directed self-checking bench for iiitb_brg_prog (default parameters).
module tb_iiitb_brg_prog;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [1:0]  sel;
  logic        use_custom;
  logic [15:0] div_cfg;
  logic        cfg_load;
  logic        sync_rst;
  logic        tick_os, baud_tick, clkout, cfg_pend, cfg_err;

  int n_asserts = 0;
  int n_fail    = 0;
  int n;
  int seen;

  iiitb_brg_prog #(.DIV_W(16), .OSR(16)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .sel(sel),
    .use_custom(use_custom), .div_cfg(div_cfg), .cfg_load(cfg_load),
    .sync_rst(sync_rst), .tick_os(tick_os), .baud_tick(baud_tick),
    .clkout(clkout), .cfg_pend(cfg_pend), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Clocks until the chosen output (0 tick_os, 1 baud_tick, 2 clkout) is
  // seen at 'level'; pulse inputs drop after the first edge. Returns the
  // budget on timeout, which never equals an expected interval.
  task automatic wait_lvl(input int which, input logic level, output int cnt);
    logic s;
    cnt = 0;
    do begin
      step();
      cfg_load = 1'b0;
      sync_rst = 1'b0;
      cnt++;
      s = (which == 0) ? tick_os : (which == 1) ? baud_tick : clkout;
    end while (s !== level && cnt < 5000);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_tick_os"},   tick_os,   0);
    chk({tag, "_baud_tick"}, baud_tick, 0);
    chk({tag, "_clkout"},    clkout,    0);
    chk({tag, "_cfg_pend"},  cfg_pend,  0);
    chk({tag, "_cfg_err"},   cfg_err,   0);
  endtask

  initial begin
    reset_n = 1'b1; en = 1'b1; sel = 2'b00; use_custom = 1'b0;
    div_cfg = '0; cfg_load = 1'b0; sync_rst = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_outs_zero("reset");
    repeat (3) step();
    reset_n = 1'b1;

    // 1: preset 68 -> ticks every 68, baud/clkout period 1088
    wait_lvl(0, 1'b1, n); chk("first_tick_after_reset", n, 69);
    wait_lvl(0, 1'b1, n); chk("tick_interval_68", n, 68);
    wait_lvl(1, 1'b1, n); chk("first_baud", n, 14 * 68);
    chk("clkout_low_at_baud", clkout, 0);
    chk("tick_with_baud", tick_os, 1);
    wait_lvl(1, 1'b1, n); chk("baud_interval", n, 1088);
    wait_lvl(2, 1'b1, n); chk("clkout_low_time", n, 544);
    wait_lvl(2, 1'b0, n); chk("clkout_high_time", n, 544);

    // 2: load sel=11 mid-period; applies at the wrap
    repeat (20) step();
    sel = 2'b11; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    chk("pend_after_load", cfg_pend, 1);
    wait_lvl(0, 1'b1, n); chk("old_period_finishes", n, 47);
    chk("pend_cleared_at_wrap", cfg_pend, 0);
    wait_lvl(0, 1'b1, n); chk("tick_interval_814", n, 814);

    // 3: custom divisor 1 clamps to 2; reload 10 clears error
    use_custom = 1'b1; div_cfg = 16'd1; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    chk("err_on_div1", cfg_err, 1);
    chk("pend_div1", cfg_pend, 1);
    wait_lvl(0, 1'b1, n); chk("814_before_clamp_applies", n, 813);
    wait_lvl(0, 1'b1, n); chk("tick_interval_2", n, 2);
    div_cfg = 16'd10; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    chk("err_cleared", cfg_err, 0);
    wait_lvl(0, 1'b1, n); chk("div2_wrap_then_apply", n, 1);
    wait_lvl(0, 1'b1, n); chk("tick_interval_10", n, 10);

    // 4: phase restart
    sync_rst = 1'b1;
    wait_lvl(0, 1'b1, n); chk("tick_after_sync", n, 11);
    chk("clkout_low_after_sync", clkout, 0);
    repeat (7) wait_lvl(0, 1'b1, n);
    chk("clkout_high_os8", clkout, 1);
    repeat (3) step();
    sync_rst = 1'b1;
    step();
    sync_rst = 1'b0;
    chk("sync_clears_clkout", clkout, 0);
    chk("sync_no_tick", tick_os, 0);
    wait_lvl(1, 1'b1, n); chk("baud_after_sync", n, 160);

    // 5: en low for 50 clocks mid-period
    repeat (8) wait_lvl(0, 1'b1, n);
    repeat (3) step();
    chk("clkout_high_before_en_low", clkout, 1);
    en = 1'b0;
    step();
    chk("en_low_clkout", clkout, 0);
    chk("en_low_tick", tick_os, 0);
    seen = 0;
    repeat (49) begin
      step();
      if (tick_os || baud_tick || clkout) seen++;
    end
    chk("quiet_while_disabled", seen, 0);
    en = 1'b1;
    wait_lvl(0, 1'b1, n); chk("tick_after_enable", n, 11);
    wait_lvl(0, 1'b1, n); chk("tick_interval_after_enable", n, 10);

    // 6: asynchronous reset mid-operation
    wait_lvl(2, 1'b1, n);
    div_cfg = 16'd0; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    chk("err_on_div0", cfg_err, 1);
    chk("clkout_high_before_reset", clkout, 1);
    #2 reset_n = 1'b0;
    #1 chk_outs_zero("async_reset");
    step(); step();
    reset_n = 1'b1;
    wait_lvl(0, 1'b1, n); chk("tick_after_rereset", n, 69);
    wait_lvl(0, 1'b1, n); chk("pre0_restored", n, 68);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
